systolic_mm_sequencer: RTL and testbench
========================================

# systolic_mm_sequencer

Job-level controller for the SIZE×SIZE systolic matrix-multiply array. It accepts one operand pair (A, B) per valid/ready handshake and holds the operands stable on the array inputs. It clears the array's accumulators, waits the fixed fill/drain latency, then captures the product matrix and presents it on a valid/ready output port. It sits between the host/DMA side and the array instance, and is the only block that drives the array's reset.

## Interface
- WIDTH, 16, result element width; matches array accumulator width.
- WIDTHx, 4, operand element width.
- SIZE, 3, matrix order N.
- RUN_CYCLES, 3*SIZE, array cycles from accumulator clear to a stable product. The 3*SIZE default covers skew of 2*(SIZE-1), plus propagation of SIZE, plus 2 cycles of margin. Must be ≥ 1.

Ports:
- clock  in  1  single clock, all state on rising edge.
- nreset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept a job.
- a_in  in  [WIDTHx-1:0] [SIZE][SIZE]  matrix A.
- b_in  in  [WIDTHx-1:0] [SIZE][SIZE]  matrix B.
- abort  in  1  cancel job in progress.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product.
- c_out  out  [WIDTH-1:0] [SIZE][SIZE]  product A·B.
- arr_nreset  out  1  array reset (active-low).
- arr_a, arr_b  out  [WIDTHx-1:0] [SIZE][SIZE]  registered operands to array.
- arr_z  in  [WIDTH-1:0] [SIZE][SIZE]  array product.
- job_count  out  16  completed-job counter (only with macro, see Configuration).

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a_in/b_in into arr_a/arr_b and go to CLEAR.
- CLEAR: one cycle. arr_nreset=0; counter loads 0. Go to RUN.
- RUN: counter increments each cycle. When counter==RUN_CYCLES-1, capture arr_z into c_out at that edge and go to DONE.
- DONE: out_valid=1 and c_out is held. On out_ready go to IDLE. No new job is accepted in the same cycle.
- abort in CLEAR or RUN: go to IDLE and zero the counter. The next cycle is still IDLE with in_ready=1. arr_nreset pulses low for the cycle following the abort, so the array never keeps partial sums.
- abort in IDLE or DONE is ignored. A completed product is never discarded by abort.
- arr_nreset = nreset AND (state≠CLEAR) AND NOT abort_pulse. It is derived from registered state only.
- arr_a/arr_b change only on an accepted handshake. They are stable for the whole CLEAR/RUN window.
- No arithmetic is done here. c_out is a width-preserving copy of arr_z.
- Counter width: $clog2(RUN_CYCLES+1).

## Timing
- Reset (nreset=0 at an edge) puts the block in IDLE, counter=0, arr_a=arr_b=0, c_out=0, out_valid=0, and job_count=0 when present.
  - in_ready is 1 from the first cycle after reset release. It is 0 while nreset=0.
  - arr_nreset is 0 while nreset=0.
- Reset mid-job drops the job with no output. nreset has priority over abort and over all handshakes.
- Latency:
  - Accepted at edge E.
  - CLEAR in cycle E+1.
  - RUN in cycles E+2 … E+1+RUN_CYCLES.
  - out_valid=1 from cycle E+2+RUN_CYCLES. With the defaults that is E+11.
- Throughput: one job per RUN_CYCLES+3 cycles at best, since DONE→IDLE takes one cycle.
- Back-pressure: out_valid and c_out hold indefinitely while out_ready=0.

## Configuration
- Macro SYSMM_SEQ_JOB_COUNT_EN.
- Defined:
  - job_count port exists. It is a 16-bit counter that increments on every out_valid&out_ready.
  - It wraps from 0xFFFF to 0. Aborted jobs are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package sysmm_pkg holds:
  - the state enum typedef (IDLE, CLEAR, RUN, DONE);
  - the default parameter constants (WIDTH, WIDTHx, SIZE);
  - a function computing default RUN_CYCLES from SIZE.
- Sub-module sysmm_seq_timer: loadable up-counter with a terminal-count flag, parameterized by RUN_CYCLES.
- The FSM and operand/result registers stay in the top module.

## Test plan
- A = identity, B = {1..9} row-major, out_ready=1.
  - c_out = B.
  - out_valid rises exactly 11 cycles after the accepting edge.
- A all 2, B all 3.
  - Every c_out element = 18.
  - Then A all 15, B all 15: every element = 675. This confirms there is no accumulation carry-over between jobs.
- Hold out_ready=0 for 20 cycles in DONE.
  - out_valid stays 1, c_out stays stable, in_ready stays 0.
  - One cycle after out_ready=1, in_ready=1.
- Assert abort in RUN cycle 4.
  - Block is in IDLE next cycle, arr_nreset=0 for one cycle, out_valid never rises.
  - A following job with identity×identity gives identity.
- Drop nreset mid-RUN.
  - All outputs are at reset values next cycle.
  - in_ready=1 after release.
- With SYSMM_SEQ_JOB_COUNT_EN defined, run 3 jobs plus 1 aborted.
  - job_count = 3.

Source files
------------

// File: rtl/sysmm_pkg.sv
// sysmm_pkg: shared state encoding, default sizes and run-length helper for the systolic MM sequencer
package sysmm_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_WIDTHX = 4;
  localparam int DEF_SIZE   = 3;
  function automatic int run_cycles(input int size);
    return 3 * size;
  endfunction
endpackage

// File: rtl/sysmm_seq_timer.sv
// sysmm_seq_timer: loadable up-counter flagging the last array cycle of a run
module sysmm_seq_timer #(
  parameter int RUN_CYCLES = 9
) (
  input  logic clock,
  input  logic nreset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = $clog2(RUN_CYCLES + 1);
  logic [CW-1:0] r_count;
  // load has priority so an abort or a fresh clear always restarts from zero
  always_ff @(posedge clock)
    if (!nreset) r_count <= '0;
    else if (i_load) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  assign o_tc = r_count == CW'(RUN_CYCLES - 1);
endmodule

// File: rtl/systolic_mm_sequencer.sv
// systolic_mm_sequencer: job controller for the SIZE x SIZE systolic array; define SYSMM_SEQ_JOB_COUNT_EN for the job_count port
module systolic_mm_sequencer
  import sysmm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int WIDTHx     = DEF_WIDTHX,
  parameter int SIZE       = DEF_SIZE,
  parameter int RUN_CYCLES = run_cycles(SIZE)
) (
  input  logic                                clock,
  input  logic                                nreset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_in,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] b_in,
  input  logic                                abort,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  c_out,
  output logic                                arr_nreset,
  output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] arr_a,
  output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] arr_b,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  arr_z
`ifdef SYSMM_SEQ_JOB_COUNT_EN
  ,
  output logic [15:0]                         job_count
`endif
);
  state_t r_state, w_next;
  logic r_abort, w_tc, w_accept, w_kill;
  assign w_accept = in_valid && in_ready;
  assign w_kill   = abort && (r_state == CLEAR || r_state == RUN);
  sysmm_seq_timer #(.RUN_CYCLES(RUN_CYCLES)) u_timer (
    .clock (clock),
    .nreset(nreset),
    .i_load(r_state == CLEAR || w_kill),
    .i_en  (r_state == RUN),
    .o_tc  (w_tc)
  );
  // state register
  always_ff @(posedge clock)
    r_state <= !nreset ? IDLE : w_next;
  // next-state logic; abort only acts while the array is working
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? CLEAR : IDLE;
      CLEAR:   w_next = abort ? IDLE : RUN;
      RUN:     w_next = abort ? IDLE : w_tc ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // outputs decoded from registered state; array reset also covers the cycle after an abort
  always_comb begin
    in_ready   = nreset && r_state == IDLE;
    out_valid  = r_state == DONE;
    arr_nreset = nreset && r_state != CLEAR && !r_abort;
  end
  // operand latch on handshake, product capture on the last run cycle
  always_ff @(posedge clock)
    if (!nreset) begin
      arr_a   <= '0;
      arr_b   <= '0;
      c_out   <= '0;
      r_abort <= 1'b0;
    end else begin
      if (w_accept) begin
        arr_a <= a_in;
        arr_b <= b_in;
      end
      if (r_state == RUN && w_tc && !abort) c_out <= arr_z;
      r_abort <= w_kill;
    end
`ifdef SYSMM_SEQ_JOB_COUNT_EN
  // completed products delivered to the consumer, wrapping at 16 bits
  always_ff @(posedge clock)
    if (!nreset) job_count <= '0;
    else if (out_valid && out_ready) job_count <= job_count + 16'd1;
`endif
endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// tb_systolic_mm_sequencer: directed table-driven bench with a behavioural array model
module tb_systolic_mm_sequencer;
  typedef logic [2:0][2:0][3:0] mat_a;
  typedef logic [2:0][2:0][15:0] mat_c;
  typedef struct {
    string nm;
    mat_a  a;
    mat_a  b;
    mat_c  c;
  } vec_t;

  logic clock = 0, nreset = 0, in_valid = 0, abort = 0, out_ready = 1;
  logic in_ready, out_valid, arr_nreset;
  mat_a a_in = '0, b_in = '0, arr_a, arr_b;
  mat_c c_out, arr_z;
`ifdef SYSMM_SEQ_JOB_COUNT_EN
  logic [15:0] job_count;
`endif
  int checks = 0, errors = 0, age = 0;

  systolic_mm_sequencer dut (
    .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .arr_nreset(arr_nreset),
    .arr_a(arr_a), .arr_b(arr_b), .arr_z(arr_z)
`ifdef SYSMM_SEQ_JOB_COUNT_EN
    , .job_count(job_count)
`endif
  );

  always #5 clock = ~clock;

  // array model: product settles only after 8 cycles out of accumulator reset, garbage before
  always @(posedge clock) age <= !arr_nreset ? 0 : (age < 100 ? age + 1 : age);
  always_comb begin
    logic [15:0] s;
    s = '0;
    arr_z = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int k = 0; k < 3; k++) s = s + 16'(arr_a[i][k]) * 16'(arr_b[k][j]);
        arr_z[i][j] = age >= 8 ? s : 16'hDEAD;
      end
  end

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic mat_a fa(input int v);
    mat_a m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 4'(v);
    return m;
  endfunction
  function automatic mat_c fc(input int v);
    mat_c m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 16'(v);
    return m;
  endfunction
  function automatic mat_a ident();
    mat_a m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 4'(i == j);
    return m;
  endfunction
  function automatic mat_c identc();
    mat_c m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 16'(i == j);
    return m;
  endfunction
  function automatic mat_a seqm();
    mat_a m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 4'(3 * i + j + 1);
    return m;
  endfunction
  function automatic mat_c seqc();
    mat_c m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 16'(3 * i + j + 1);
    return m;
  endfunction
  function automatic mat_c sqc();
    int v[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    mat_c m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = 16'(v[3 * i + j]);
    return m;
  endfunction
  function automatic vec_t mk(input string nm, input mat_a a, input mat_a b, input mat_c c);
    vec_t v;
    v.nm = nm; v.a = a; v.b = b; v.c = c;
    return v;
  endfunction

  // offers a job and returns at the negedge of the CLEAR cycle
  task automatic start_job(input mat_a a, input mat_a b, input string nm);
    @(negedge clock);
    chk({nm, " in_ready"}, in_ready, 1);
    a_in = a; b_in = b; in_valid = 1;
    @(negedge clock);
    in_valid = 0; a_in = '0; b_in = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_job(input mat_a a, input mat_a b, input mat_c e, input string nm);
    int n;
    start_job(a, b, nm);
    chk({nm, " clear"}, arr_nreset, 0);
    wait_valid(n);
    chk({nm, " latency"}, 144'(n), 144'(11));
    chk({nm, " c_out"}, c_out, e);
    @(negedge clock);
    chk({nm, " back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    vec_t vecs[5];
    int n;
    logic bad;
    vecs[0] = mk("id_x_seq", ident(), seqm(), seqc());
    vecs[1] = mk("all2_x_all3", fa(2), fa(3), fc(18));
    vecs[2] = mk("all15_x_all15", fa(15), fa(15), fc(675));
    vecs[3] = mk("seq_x_id", seqm(), ident(), seqc());
    vecs[4] = mk("seq_x_seq", seqm(), seqm(), sqc());

    repeat (2) @(negedge clock);
    chk("rst in_ready", in_ready, 0);
    chk("rst arr_nreset", arr_nreset, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst c_out", c_out, 0);
    nreset = 1;
    @(negedge clock);
    chk("post_rst in_ready", {in_ready, arr_nreset}, 2'b11);

    for (int i = 0; i < 5; i++) do_job(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].nm);

    // back-pressure in DONE, with an abort that must be ignored
    out_ready = 0;
    start_job(fa(2), fa(3), "bp");
    wait_valid(n);
    chk("bp reached", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      abort = i == 5;
      @(negedge clock);
      chk("bp hold", {in_ready, out_valid}, 2'b01);
      chk("bp c_out", c_out, fc(18));
    end
    abort = 0;
    out_ready = 1;
    @(negedge clock);
    chk("bp release", {in_ready, out_valid}, 2'b10);

    // abort in RUN cycle 4
    start_job(seqm(), seqm(), "abort");
    repeat (4) @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    chk("abort idle", {in_ready, out_valid, arr_nreset}, 3'b100);
    @(negedge clock);
    chk("abort arr_nreset back", arr_nreset, 1);
    bad = 0;
    repeat (15) begin
      @(negedge clock);
      bad |= out_valid;
    end
    chk("abort no out_valid", bad, 0);
    do_job(ident(), ident(), identc(), "id_x_id");

    // reset mid-RUN drops the job
    start_job(fa(15), fa(15), "rst_mid");
    repeat (4) @(negedge clock);
    nreset = 0;
    chk("rst_mid in_ready low", in_ready, 0);
    @(negedge clock);
    chk("rst_mid flags", {in_ready, out_valid, arr_nreset}, 3'b000);
    chk("rst_mid c_out", c_out, 0);
    chk("rst_mid arr_a", arr_a, 0);
    chk("rst_mid arr_b", arr_b, 0);
    nreset = 1;
    @(negedge clock);
    chk("rst_mid release", {in_ready, out_valid, arr_nreset}, 3'b101);

`ifdef SYSMM_SEQ_JOB_COUNT_EN
    chk("jc before", job_count, 0);
    do_job(fa(1), fa(1), fc(3), "jc1");
    do_job(fa(2), fa(1), fc(6), "jc2");
    start_job(fa(1), fa(1), "jc_abort");
    repeat (3) @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    repeat (2) @(negedge clock);
    do_job(fa(1), fa(2), fc(6), "jc3");
    chk("job_count", job_count, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
